// File: rtl/store_merge_unit_if.sv
// Store request / data-memory bus bundle for store_merge_unit.
// The slave side is the merge unit; the master side is MEM stage plus memory.
interface store_merge_unit_if #(
  parameter int NBITS    = 32,
  parameter int ADDRBITS = 10,
  parameter int TNBITS   = 2
);
  logic                  i_valid;
  logic [ADDRBITS+1:0]   i_addr;
  logic [NBITS-1:0]      i_dato;
  logic [TNBITS-1:0]     i_tamano;
  logic                  o_ready;
  logic                  o_stall;
  logic [ADDRBITS-1:0]   o_mem_addr;
  logic                  o_mem_re;
  logic                  o_mem_we;
  logic [NBITS-1:0]      o_mem_wdata;
  logic [NBITS-1:0]      i_mem_rdata;
  logic                  o_done;
  logic                  o_error;

  modport master (
    output i_valid, i_addr, i_dato, i_tamano, i_mem_rdata,
    input  o_ready, o_stall, o_mem_addr, o_mem_re, o_mem_we,
           o_mem_wdata, o_done, o_error
  );

  modport slave (
    input  i_valid, i_addr, i_dato, i_tamano, i_mem_rdata,
    output o_ready, o_stall, o_mem_addr, o_mem_re, o_mem_we,
           o_mem_wdata, o_done, o_error
  );
endinterface

// File: rtl/store_merge_unit.sv
// Data-memory store path: word stores write directly, byte/halfword stores
// read-modify-write the target word, misaligned or illegal requests are dropped.
module store_merge_unit #(
  parameter int NBITS    = 32,
  parameter int ADDRBITS = 10,
  parameter int TNBITS   = 2
) (
  input logic               i_clk,
  input logic               i_reset,
  store_merge_unit_if.slave bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_MERGE = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [TNBITS-1:0] SZ_WORD = TNBITS'(0);
  localparam logic [TNBITS-1:0] SZ_BYTE = TNBITS'(1);
  localparam logic [TNBITS-1:0] SZ_HALF = TNBITS'(2);

  logic [2:0]          state_q, state_d;
  logic [ADDRBITS-1:0] addr_q, addr_d;
  logic [1:0]          lane_q, lane_d;
  logic [NBITS-1:0]    data_q, data_d;
  logic [TNBITS-1:0]   size_q, size_d;

  logic                accept;
  logic [1:0]          req_lane;
  logic [NBITS-1:0]    merged;

  assign accept   = bus.i_valid && (state_q == ST_IDLE);
  assign req_lane = bus.i_addr[1:0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lane_d  = lane_q;
    data_d  = data_q;
    size_d  = size_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d = bus.i_addr[ADDRBITS+1:2];
          lane_d = req_lane;
          data_d = bus.i_dato;
          size_d = bus.i_tamano;
          if (bus.i_tamano == SZ_WORD && req_lane == 2'b00) begin
            state_d = ST_WRITE;
          end else if (bus.i_tamano == SZ_BYTE) begin
            state_d = ST_READ;
          end else if (bus.i_tamano == SZ_HALF && !req_lane[0]) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_READ:  state_d = ST_MERGE;
      ST_MERGE: state_d = ST_IDLE;
      ST_WRITE: state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Lanes are little-endian; a halfword uses only lane[1] to pick its half.
  always_comb begin
    merged = bus.i_mem_rdata;
    if (size_q == SZ_HALF) begin
      merged[{lane_q[1], 4'b0000} +: 16] = data_q[15:0];
    end else begin
      merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
    end
  end

  always_comb begin
    bus.o_ready     = (state_q == ST_IDLE);
    bus.o_stall     = (state_q != ST_IDLE) || accept;
    bus.o_mem_addr  = (state_q == ST_IDLE) ? '0 : addr_q;
    bus.o_mem_re    = (state_q == ST_READ);
    bus.o_mem_we    = (state_q == ST_MERGE) || (state_q == ST_WRITE);
    bus.o_done      = (state_q == ST_MERGE) || (state_q == ST_WRITE);
    bus.o_error     = (state_q == ST_ERR);
    bus.o_mem_wdata = '0;
    if (state_q == ST_MERGE) begin
      bus.o_mem_wdata = merged;
    end else if (state_q == ST_WRITE) begin
      bus.o_mem_wdata = data_q;
    end
  end

  // Strobes are decoded from state, so an async reset kills them at once.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      size_q  <= size_d;
    end
  end

endmodule
